uart_loader: RTL and testbench

//  UART program loader feeding the Init/InitPC/Init_Data path of the board top level.
//  It receives a framed image over Rx and writes it word-by-word into instruction memory.

---
 rtl/uart_loader_pkg.sv | 11 +
 rtl/uart_loader_rx.sv | 106 ++++++++++
 rtl/uart_loader.sv | 179 +++++++++++++++++
 tb/tb_uart_loader.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_loader_pkg.sv
// Shared types and protocol constants for the UART program loader.
package uart_loader_pkg;

  typedef enum logic [2:0] {IDLE, HDR_ADDR, HDR_CNT, DATA, CSUM, RESP} loader_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

endpackage

// File: rtl/uart_loader_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling, stop-bit check.
module uart_rx
  import uart_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       rx_valid,
  output logic [7:0] rx_byte,
  output logic       rx_frame_err
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);

  rx_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          meta_q, sync_q, prev_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      RX_IDLE: begin
        if (prev_q && !sync_q) begin
          state_d = RX_START;
          cnt_d   = HALF_LOAD;
        end
      end
      RX_START: begin
        if (cnt_q == '0) begin
          // A glitch shorter than half a bit falls back to idle here.
          if (!sync_q) begin
            state_d = RX_DATA;
            cnt_d   = FULL_LOAD;
            bit_d   = 3'd0;
          end else begin
            state_d = RX_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == '0) begin
          byte_d = {sync_q, byte_q[7:1]};
          cnt_d  = FULL_LOAD;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = RX_STOP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt_q == '0) begin
          state_d = RX_IDLE;
          valid_d = sync_q;
          ferr_d  = !sync_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      prev_q  <= 1'b1;
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      meta_q  <= rx;
      sync_q  <= meta_q;
      prev_q  <= sync_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
    end
  end

  assign rx_valid     = valid_q;
  assign rx_byte      = byte_q;
  assign rx_frame_err = ferr_q;

endmodule

// File: rtl/uart_loader.sv
// Frame FSM, word assembler, checksum and ACK/NAK transmitter for the UART loader.
module uart_loader
  import uart_loader_pkg::*;
#(
  parameter int CLK_HZ       = 100_000_000,
  parameter int BAUD         = 115_200,
  parameter int TIMEOUT_BITS = 64
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        Rx,
  output logic        Tx,
  output logic        Init,
  output logic        Init_WE,
  output logic [31:0] Init_ADDR,
  output logic [31:0] Init_Data,
  output logic [31:0] InitPC,
  output logic        load_err
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int BW           = $clog2(CLKS_PER_BIT);
  localparam int TO_CYCLES    = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int TW           = $clog2(TO_CYCLES);
  localparam logic [BW-1:0] BIT_LOAD = BW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TO_LOAD  = TW'(TO_CYCLES - 1);

  logic       rx_valid, rx_frame_err;
  logic [7:0] rx_byte;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk         (CLK),
    .rst_n       (RST_N),
    .rx          (Rx),
    .rx_valid    (rx_valid),
    .rx_byte     (rx_byte),
    .rx_frame_err(rx_frame_err)
  );

  loader_state_t state_q, state_d;
  logic [31:0]   addr_q, addr_d, start_q, start_d, word_q, word_d;
  logic [31:0]   waddr_q, waddr_d, wdata_q, wdata_d, pc_q, pc_d;
  logic [15:0]   left_q, left_d;
  logic [1:0]    bcnt_q, bcnt_d;
  logic [7:0]    csum_q, csum_d;
  logic [TW-1:0] to_q, to_d;
  logic          we_q, we_d, err_q, err_d, init_q, init_d;
  logic [9:0]    tx_sh_q, tx_sh_d;
  logic [BW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]    tx_bits_q, tx_bits_d;
  logic          rx_active, start_tx;
  logic [7:0]    reply;

  always_comb begin
    state_d = state_q;  addr_d = addr_q;  start_d = start_q;  word_d = word_q;
    waddr_d = waddr_q;  wdata_d = wdata_q; pc_d = pc_q;       left_d = left_q;
    bcnt_d  = bcnt_q;   csum_d = csum_q;  to_d = to_q;        we_d = 1'b0;
    err_d   = err_q;    init_d = init_q;  tx_sh_d = tx_sh_q;
    tx_cnt_d = tx_cnt_q; tx_bits_d = tx_bits_q;
    start_tx = 1'b0;
    reply    = NAK_BYTE;
    rx_active = (state_q == HDR_ADDR) || (state_q == HDR_CNT) ||
                (state_q == DATA) || (state_q == CSUM);
    if (rx_active) to_d = rx_valid ? TO_LOAD : to_q - 1'b1;

    case (state_q)
      IDLE: begin
        if (rx_valid && rx_byte == SYNC_BYTE) begin
          state_d = HDR_ADDR;
          init_d  = 1'b1;
          err_d   = 1'b0;
          csum_d  = 8'h00;
          bcnt_d  = 2'd0;
          to_d    = TO_LOAD;
        end
      end
      HDR_ADDR: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          addr_d = {rx_byte, addr_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            start_d = {rx_byte, addr_q[31:8]};
            state_d = HDR_CNT;
          end
        end
      end
      HDR_CNT: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          left_d = {rx_byte, left_q[15:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd1) begin
            bcnt_d  = 2'd0;
            state_d = ({rx_byte, left_q[15:8]} == 16'd0) ? CSUM : DATA;
          end
        end
      end
      DATA: begin
        if (rx_valid) begin
          csum_d = csum_q ^ rx_byte;
          word_d = {rx_byte, word_q[31:8]};
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            we_d    = 1'b1;
            waddr_d = addr_q;
            wdata_d = {rx_byte, word_q[31:8]};
            addr_d  = addr_q + 32'd4;
            left_d  = left_q - 16'd1;
            if (left_q == 16'd1) state_d = CSUM;
          end
        end
      end
      CSUM: begin
        if (rx_valid) begin
          start_tx = 1'b1;
          if (rx_byte == csum_q) begin
            reply = ACK_BYTE;
            pc_d  = start_q;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      RESP: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d  = BIT_LOAD;
          tx_sh_d   = {1'b1, tx_sh_q[9:1]};
          tx_bits_d = tx_bits_q - 4'd1;
          if (tx_bits_q == 4'd1) begin
            state_d = IDLE;
            init_d  = 1'b0;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort on a bad stop bit or an idle line; a byte arriving the same cycle wins.
    if (rx_active && !rx_valid && (rx_frame_err || to_q == '0)) begin
      start_tx = 1'b1;
      reply    = NAK_BYTE;
      err_d    = 1'b1;
    end
    if (start_tx) begin
      state_d   = RESP;
      tx_sh_d   = {1'b1, reply, 1'b0};
      tx_cnt_d  = BIT_LOAD;
      tx_bits_d = 4'd10;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;  addr_q <= '0;  start_q <= '0;  word_q <= '0;
      waddr_q <= '0;    wdata_q <= '0; pc_q <= '0;     left_q <= '0;
      bcnt_q  <= '0;    csum_q <= '0;  to_q <= '0;     we_q <= 1'b0;
      err_q   <= 1'b0;  init_q <= 1'b0; tx_sh_q <= '1;
      tx_cnt_q <= '0;   tx_bits_q <= '0;
    end else begin
      state_q <= state_d;  addr_q <= addr_d;   start_q <= start_d; word_q <= word_d;
      waddr_q <= waddr_d;  wdata_q <= wdata_d; pc_q <= pc_d;       left_q <= left_d;
      bcnt_q  <= bcnt_d;   csum_q <= csum_d;   to_q <= to_d;       we_q <= we_d;
      err_q   <= err_d;    init_q <= init_d;   tx_sh_q <= tx_sh_d;
      tx_cnt_q <= tx_cnt_d; tx_bits_q <= tx_bits_d;
    end
  end

  assign Tx        = tx_sh_q[0];
  assign Init      = init_q;
  assign Init_WE   = we_q;
  assign Init_ADDR = waddr_q;
  assign Init_Data = wdata_q;
  assign InitPC    = pc_q;
  assign load_err  = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// Scoreboard bench for uart_loader at 8 clocks per bit.
module tb_uart_loader;

  logic        clk = 1'b0;
  logic        RST_N = 1'b0;
  logic        Rx = 1'b1;
  logic        Tx, Init, Init_WE, load_err;
  logic [31:0] Init_ADDR, Init_Data, InitPC;

  int errors = 0;
  int checks = 0;

  logic [63:0] wq[$];
  logic [7:0]  rq[$];
  logic [7:0]  bcs;
  logic [31:0] waddr;

  always #5 clk = ~clk;

  uart_loader #(.CLK_HZ(800), .BAUD(100), .TIMEOUT_BITS(64)) dut (
    .CLK(clk), .RST_N(RST_N), .Rx(Rx), .Tx(Tx), .Init(Init), .Init_WE(Init_WE),
    .Init_ADDR(Init_ADDR), .Init_Data(Init_Data), .InitPC(InitPC), .load_err(load_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // write monitor
  always @(negedge clk) begin
    if (RST_N && Init_WE) begin
      if (wq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write got=%h:%h exp=none", Init_ADDR, Init_Data);
      end else begin
        logic [63:0] e;
        e = wq.pop_front();
        chk("we_addr", Init_ADDR, e[63:32]);
        chk("we_data", Init_Data, e[31:0]);
      end
    end
  end

  // Tx decoder
  initial begin
    logic [7:0] mb;
    forever begin
      @(negedge clk);
      if (RST_N && Tx === 1'b0) begin
        repeat (4) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (8) @(negedge clk);
          mb[i] = Tx;
        end
        repeat (8) @(negedge clk);
        chk("tx_stop", {31'd0, Tx}, 32'd1);
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_tx got=%h exp=none", mb);
        end else begin
          chk("tx_byte", {24'd0, mb}, {24'd0, rq.pop_front()});
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    Rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      Rx = b[i];
      repeat (8) @(negedge clk);
    end
    Rx = bad_stop ? 1'b0 : 1'b1;
    repeat (8) @(negedge clk);
    Rx = 1'b1;
  endtask

  task automatic fb(input logic [7:0] b);
    bcs = bcs ^ b;
    send_byte(b, 1'b0);
  endtask

  task automatic hdr(input logic [31:0] a, input logic [15:0] n);
    send_byte(8'hA5, 1'b0);
    chk("init_hi", {31'd0, Init}, 32'd1);
    chk("err_clr", {31'd0, load_err}, 32'd0);
    bcs = 8'h00;
    waddr = a;
    fb(a[7:0]); fb(a[15:8]); fb(a[23:16]); fb(a[31:24]);
    fb(n[7:0]); fb(n[15:8]);
  endtask

  task automatic word(input logic [31:0] d);
    wq.push_back({waddr, d});
    waddr = waddr + 32'd4;
    fb(d[7:0]); fb(d[15:8]); fb(d[23:16]); fb(d[31:24]);
  endtask

  task automatic tail(input logic [7:0] flip, input bit ack);
    rq.push_back(ack ? 8'h06 : 8'h15);
    send_byte(bcs ^ flip, 1'b0);
  endtask

  task automatic finish_frame(input string name, input logic [31:0] pc, input logic err);
    int n;
    n = 0;
    while (Init && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_init_lo"}, {31'd0, Init}, 32'd0);
    chk({name, "_pc"}, InitPC, pc);
    chk({name, "_err"}, {31'd0, load_err}, {31'd0, err});
    chk({name, "_wq_left"}, wq.size(), 32'd0);
    chk({name, "_rq_left"}, rq.size(), 32'd0);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #900_000;
    errors++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, Tx}, 32'd1);
    chk("rst_init", {31'd0, Init}, 32'd0);
    chk("rst_pc", InitPC, 32'd0);
    chk("rst_err", {31'd0, load_err}, 32'd0);
    RST_N = 1'b1;
    repeat (4) @(negedge clk);

    // good two-word frame
    hdr(32'h0000_0100, 16'd2);
    word(32'h0000_0013); word(32'h0010_0093);
    tail(8'h00, 1'b1);
    finish_frame("t1", 32'h0000_0100, 1'b0);

    // bad checksum: writes still land, PC holds
    hdr(32'h0000_0100, 16'd2);
    word(32'h0000_0013); word(32'h0010_0093);
    tail(8'h01, 1'b0);
    finish_frame("t2", 32'h0000_0100, 1'b1);

    // empty frame
    hdr(32'h0000_0040, 16'd0);
    tail(8'h00, 1'b1);
    finish_frame("t3", 32'h0000_0040, 1'b0);

    // garbage before a frame
    send_byte(8'h00, 1'b0);
    chk("garb0_init", {31'd0, Init}, 32'd0);
    send_byte(8'hFF, 1'b0);
    chk("garbff_init", {31'd0, Init}, 32'd0);
    hdr(32'h0000_0080, 16'd1);
    word(32'hDEAD_BEEF);
    tail(8'h00, 1'b1);
    finish_frame("t4", 32'h0000_0080, 1'b0);

    // stall after 3 data bytes
    hdr(32'h0000_0200, 16'd1);
    rq.push_back(8'h15);
    fb(8'h11); fb(8'h22); fb(8'h33);
    finish_frame("t5", 32'h0000_0080, 1'b1);

    // bad stop bit mid-frame
    hdr(32'h0000_0300, 16'd1);
    rq.push_back(8'h15);
    send_byte(8'h5A, 1'b1);
    finish_frame("t6", 32'h0000_0080, 1'b1);

    // address wrap
    hdr(32'hFFFF_FFFC, 16'd2);
    word(32'h1111_1111); word(32'h2222_2222);
    tail(8'h00, 1'b1);
    finish_frame("t7", 32'hFFFF_FFFC, 1'b0);

    // reset mid-DATA
    hdr(32'h0000_0500, 16'd2);
    fb(8'h01); fb(8'h02);
    RST_N = 1'b0;
    #1;
    chk("mrst_tx", {31'd0, Tx}, 32'd1);
    chk("mrst_init", {31'd0, Init}, 32'd0);
    chk("mrst_we", {31'd0, Init_WE}, 32'd0);
    chk("mrst_addr", Init_ADDR, 32'd0);
    chk("mrst_data", Init_Data, 32'd0);
    chk("mrst_pc", InitPC, 32'd0);
    chk("mrst_err", {31'd0, load_err}, 32'd0);
    repeat (3) @(negedge clk);
    RST_N = 1'b1;
    repeat (4) @(negedge clk);
    hdr(32'h0000_0600, 16'd1);
    word(32'hCAFE_F00D);
    tail(8'h00, 1'b1);
    finish_frame("t8", 32'h0000_0600, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
